// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: the fetch-side word, redirect and decode handshake.
// Ports: fetch_instr_pc/flush/dispatch_ready in; busy, out0_*, out1_*, overflow out.
interface instr_fetch_queue_if;
    logic [63:0] fetch_instr_pc;
    logic        flush;
    logic        dispatch_ready;
    logic        busy;
    logic        out0_valid;
    logic [31:0] out0_instr;
    logic [31:0] out0_pc;
    logic        out1_valid;
    logic [31:0] out1_instr;
    logic [31:0] out1_pc;
    logic        overflow;

    modport master (
        output fetch_instr_pc, flush, dispatch_ready,
        input  busy, out0_valid, out0_instr, out0_pc,
        input  out1_valid, out1_instr, out1_pc, overflow
    );

    modport slave (
        input  fetch_instr_pc, flush, dispatch_ready,
        output busy, out0_valid, out0_instr, out0_pc,
        output out1_valid, out1_instr, out1_pc, overflow
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Dual-issue instruction buffer between cache controller and decode.
// Ports: clk, rst (async, active-high), ifq (slave side of instr_fetch_queue_if).
module instr_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input logic              clk,
    input logic              rst,
    instr_fetch_queue_if.slave ifq
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_BUSY = (AW+1)'(DEPTH - 2);
    localparam logic [AW:0] CNT_TWO  = (AW+1)'(2);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] rp;
    logic [AW-1:0] wp;
    logic [AW-1:0] rp1;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_next;
    logic          ovf;
    logic          push;
    logic          full;
    logic          push_ok;
    logic [1:0]    pop;
    logic [63:0]   head;
    logic [63:0]   second;

    // Fullness is judged before this cycle's pop, so a full queue
    // drops the incoming word even when decode drains that cycle.
    assign push    = |ifq.fetch_instr_pc;
    assign full    = (cnt == CNT_FULL);
    assign push_ok = push && !full;

    always_comb begin
        pop = 2'd0;
        if (ifq.dispatch_ready) begin
            if (cnt >= CNT_TWO) pop = 2'd2;
            else                pop = cnt[1:0];
        end
    end

    assign cnt_next = cnt + (AW+1)'(push_ok) - (AW+1)'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (ifq.flush) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            rp  <= rp + AW'(pop);
            cnt <= cnt_next;
            if (push_ok) wp <= wp + 1'b1;
            if (push && full) ovf <= 1'b1;
        end
    end

    // Storage is not reset; only entries behind a valid count are shown.
    always_ff @(posedge clk) begin
        if (push_ok && !ifq.flush) mem[wp] <= ifq.fetch_instr_pc;
    end

    assign rp1    = rp + 1'b1;
    assign head   = mem[rp];
    assign second = mem[rp1];

    assign ifq.busy       = (cnt >= CNT_BUSY);
    assign ifq.overflow   = ovf;
    assign ifq.out0_valid = (cnt != '0);
    assign ifq.out1_valid = (cnt >= CNT_TWO);
    assign ifq.out0_instr = ifq.out0_valid ? head[63:32]   : 32'd0;
    assign ifq.out0_pc    = ifq.out0_valid ? head[31:0]    : 32'd0;
    assign ifq.out1_instr = ifq.out1_valid ? second[63:32] : 32'd0;
    assign ifq.out1_pc    = ifq.out1_valid ? second[31:0]  : 32'd0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios then random traffic.
// Reference model is a plain queue of words plus a sticky overflow bit.
module tb_instr_fetch_queue;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(.DEPTH(DEPTH), .AW(3)) dut (
        .clk (clk),
        .rst (rst),
        .ifq (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] mq[$];
    logic        m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs();
        logic [63:0] e0;
        logic [63:0] e1;
        int n;
        n  = mq.size();
        e0 = (n >= 1) ? mq[0] : 64'd0;
        e1 = (n >= 2) ? mq[1] : 64'd0;
        chk("busy",       64'(bus.busy),       64'(n >= DEPTH - 2));
        chk("overflow",   64'(bus.overflow),   64'(m_ovf));
        chk("out0_valid", 64'(bus.out0_valid), 64'(n >= 1));
        chk("out1_valid", 64'(bus.out1_valid), 64'(n >= 2));
        chk("out0", {bus.out0_instr, bus.out0_pc}, e0);
        chk("out1", {bus.out1_instr, bus.out1_pc}, e1);
    endtask

    task automatic model_edge(input logic [63:0] w, input logic fl,
                              input logic dr);
        int n;
        int p;
        if (fl) begin
            mq.delete();
            return;
        end
        n = mq.size();
        p = dr ? ((n < 2) ? n : 2) : 0;
        repeat (p) void'(mq.pop_front());
        if (w != 64'd0) begin
            if (n == DEPTH) m_ovf = 1'b1;
            else            mq.push_back(w);
        end
    endtask

    // Called at a falling edge: check state, drive, clock, advance model.
    task automatic step(input logic [63:0] w, input logic fl,
                        input logic dr);
        check_outs();
        bus.fetch_instr_pc = w;
        bus.flush          = fl;
        bus.dispatch_ready = dr;
        @(posedge clk);
        model_edge(w, fl, dr);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.fetch_instr_pc = {32'h13, 32'h4};
        bus.flush          = 1'b0;
        bus.dispatch_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        check_outs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs();
        rst = 1'b0;
    endtask

    function automatic logic [63:0] wd(input int pc);
        return {32'h13, 32'(pc)};
    endfunction

    initial begin
        bus.fetch_instr_pc = 64'd0;
        bus.flush          = 1'b0;
        bus.dispatch_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // first push, one-cycle fill latency
        step(wd(0), 0, 0);
        chk("first_pc", 64'(bus.out0_pc), 64'd0);
        chk("first_v1", 64'(bus.out1_valid), 64'd0);

        // fill to busy, then overflow on the 9th push
        for (int i = 1; i < 9; i++) step(wd(4 * i), 0, 0);
        step(64'd0, 0, 0);
        chk("ovf_set", 64'(bus.overflow), 64'd1);

        // dual drain of 6 entries
        do_reset();
        for (int i = 0; i < 6; i++) step(wd(4 * i), 0, 0);
        for (int i = 0; i < 3; i++) step(64'd0, 0, 1);
        step(64'd0, 0, 0);

        // odd drain with simultaneous push
        step(wd(32'h18), 0, 0);
        step(wd(32'h20), 0, 1);
        chk("odd_pc", 64'(bus.out0_pc), 64'h20);

        // push into full queue alongside a 2-pop
        for (int i = 0; i < 7; i++) step(wd(32'h100 + 4 * i), 0, 0);
        step(wd(32'h200), 0, 1);
        step(64'd0, 0, 0);

        // wrap: 20 entries with interleaved 2-pops
        do_reset();
        for (int i = 0; i < 20; i++) step(wd(32'h400 + 4 * i), 0, i[0]);
        for (int i = 0; i < 6; i++) step(64'd0, 0, 1);

        // flush with 5 queued and a same-cycle push
        do_reset();
        for (int i = 0; i < 5; i++) step(wd(4 * i), 0, 0);
        step(wd(32'h40), 1, 1);
        chk("flush_v0", 64'(bus.out0_valid), 64'd0);
        step(wd(32'h80), 0, 0);
        step(64'd0, 0, 0);
        chk("flush_head", 64'(bus.out0_pc), 64'h80);

        // random traffic with occasional async reset
        for (int i = 0; i < 2000; i++) begin
            logic [63:0] w;
            logic fl;
            logic dr;
            w  = ($urandom_range(0, 9) < 7) ?
                 {32'($urandom), 32'($urandom)} : 64'd0;
            if (bus.busy && $urandom_range(0, 3) != 0) w = 64'd0;
            fl = ($urandom_range(0, 39) == 0);
            dr = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            else step(w, fl, dr);
        end
        check_outs();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
